store_align_buffer: RTL and testbench
=====================================

// Module: store_align_buffer
// PURPOSE
//   Write-side counterpart of the load/immediate extension path: narrows and places
//   sb/sh/sw store data into the correct byte lanes of a 32-bit memory word, builds
//   per-lane byte enables, flags misaligned stores, and queues aligned writes in a
//   small FIFO. Sits between the MEM stage and the data memory; the memory may stall.
// PARAMETERS
//   DEPTH   2   FIFO entries; power of two, >= 2
// PORTS
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   req_valid  in   1   MEM stage presents a store
//   req_ready  out  1   buffer can accept a store this cycle
//   req_addr   in   32  byte address of the store
//   req_wdata  in   32  store source data; low byte/half/word is used
//   req_size   in   2   0=byte, 1=half, 2=word, 3=illegal
//   mem_valid  out  1   head entry valid toward data memory
//   mem_ready  in   1   data memory accepts head entry this cycle
//   mem_addr   out  32  word address {addr[31:2],2'b00}
//   mem_wdata  out  32  lane-placed write data
//   mem_be     out  4   byte enables, bit i = byte lane i (bits [8i+7:8i])
//   misalign   out  1   one-cycle pulse: previous accepted store was misaligned
//   count      out  $clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-transfer): count=0, pointers=0, mem_valid=0,
//     misalign=0; queued entries discarded. Outputs valid from first edge after release.
//   - req_ready = (count != DEPTH); no same-cycle bypass of a pop into a full FIFO.
//   - Accept = req_valid & req_ready. Pop = mem_valid & mem_ready.
//   - Alignment (a = req_addr[1:0]):
//       byte: wdata={4{d[7:0]}},  be=4'b0001<<a, never misaligned
//       half: wdata={2{d[15:0]}}, be= a[1]?4'b1100:4'b0011, misaligned if a[0]
//       word: wdata=d,            be=4'b1111, misaligned if a!=0
//       size 3: always misaligned
//   - Misaligned store: handshake completes (consumes req), NOT enqueued; misalign=1
//     for exactly the cycle after acceptance, else 0.
//   - Latency: aligned store accepted at edge N -> mem_valid=1 during cycle N+1 at
//     the earliest (registered FIFO storage, no combinational req->mem path).
//   - mem_valid = (count != 0). While mem_valid & !mem_ready, mem_addr/wdata/be hold
//     stable. When count==0, mem_addr/wdata/be drive 0.
//   - Simultaneous accept (aligned) and pop: count unchanged, both pointers advance.
//     Accept of misaligned store with pop: count decrements.
//   - Pointers wrap modulo DEPTH; FIFO order strictly preserved.
//   - No state machine beyond FIFO occupancy: EMPTY (count=0) / PARTIAL / FULL
//     (count=DEPTH); transitions only by accept/pop as above.
// TESTING
//   1. sb addr=0x1003 data=0x000000A5, mem_ready=1 -> next cycle mem_addr=0x1000,
//      mem_wdata=0xA5A5A5A5, mem_be=4'b1000, misalign=0.
//   2. sh addr=0x2002 data=0x1234BEEF -> mem_wdata=0xBEEFBEEF, mem_be=4'b1100;
//      sh addr=0x2001 -> misalign pulses 1 cycle, count stays 0, no mem_valid.
//   3. mem_ready=0, push 2 aligned sw (DEPTH=2) -> count=2, req_ready=0, head
//      outputs stable; raise mem_ready -> entries drain in order, count 2->1->0.
//   4. count=1, same-cycle aligned push and pop -> count stays 1, new entry at head
//      next cycle.
//   5. Assert reset while count=2 and mem_ready=0 -> mem_valid=0, count=0
//      immediately (asynchronous), misalign=0.
//   6. sw addr=0x3000 size=3 -> misalign pulse, nothing enqueued, req_ready stays 1.

Source files
------------

// File: rtl/store_align_buffer.sv
// Store alignment buffer: places sb/sh/sw data into byte lanes, builds byte enables,
// drops misaligned stores with a one-cycle flag, and queues aligned writes in a FIFO.
module store_align_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    input  logic [1:0]               req_size,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     misalign,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    function automatic logic [31:0] place_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    place_data = {4{d[7:0]}};
            2'd1:    place_data = {2{d[15:0]}};
            default: place_data = d;
        endcase
    endfunction

    function automatic logic [3:0] place_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    place_be = 4'b0001 << a;
            2'd1:    place_be = a[1] ? 4'b1100 : 4'b0011;
            default: place_be = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = a[0];
            2'd2:    is_misaligned = (a != 2'd0);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    // Stage p0: combinational lane placement of the incoming request
    logic        accept_p0;
    logic        mis_p0;
    logic        push_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  be_p0;
    logic        pop;

    assign accept_p0 = req_valid & req_ready;
    assign mis_p0    = is_misaligned(req_size, req_addr[1:0]);
    assign push_p0   = accept_p0 & ~mis_p0;
    assign wdata_p0  = place_data(req_size, req_wdata);
    assign be_p0     = place_be(req_size, req_addr[1:0]);
    assign pop       = mem_valid & mem_ready;

    // Stage p1: FIFO storage; data is never reset, validity comes from count
    logic [29:0]   addr_p1  [DEPTH];
    logic [31:0]   wdata_p1 [DEPTH];
    logic [3:0]    be_p1    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push_p0) begin
            addr_p1[wr_ptr]  <= req_addr[31:2];
            wdata_p1[wr_ptr] <= wdata_p0;
            be_p1[wr_ptr]    <= be_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            if (push_p0) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_p0, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            misalign <= accept_p0 & mis_p0;
        end
    end

    assign mem_valid = (count != '0);
    assign req_ready = (count != CW'(DEPTH));
    assign mem_addr  = mem_valid ? {addr_p1[rd_ptr], 2'b00} : '0;
    assign mem_wdata = mem_valid ? wdata_p1[rd_ptr] : '0;
    assign mem_be    = mem_valid ? be_p1[rd_ptr] : '0;

endmodule

// File: tb/tb_store_align_buffer.sv
// Bench for store_align_buffer: directed scenarios plus random traffic against a
// queue-based reference model of the store alignment buffer.
module tb_store_align_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    store_align_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .misalign(misalign), .count(count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    logic exp_mis;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-count arithmetic rather than lane muxing
    function automatic void ref_align(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sz, output logic mis, output ent_t e);
        int nb;
        int off;
        logic [7:0]  b;
        logic [15:0] h;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        b   = d[7:0];
        h   = d[15:0];
        mis = (sz == 2'd3) || ((a % nb) != 0);
        e.addr = a - (a % 4);
        case (sz)
            2'd0: begin e.wdata = 32'(b) * 32'h0101_0101; e.be = 4'(1 << off); end
            2'd1: begin e.wdata = 32'(h) * 32'h0001_0001; e.be = 4'(3 << off); end
            default: begin e.wdata = d; e.be = 4'hF; end
        endcase
    endfunction

    task automatic check_outputs();
        ent_t head;
        head.addr = '0; head.wdata = '0; head.be = '0;
        if (q.size() != 0) head = q[0];
        chk("req_ready", 32'(req_ready), 32'(q.size() != DEPTH));
        chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
        chk("count",     32'(count),     32'(q.size()));
        chk("misalign",  32'(misalign),  32'(exp_mis));
        chk("mem_addr",  mem_addr,       head.addr);
        chk("mem_wdata", mem_wdata,      head.wdata);
        chk("mem_be",    32'(mem_be),    32'(head.be));
    endtask

    // Called at posedge+1: drive, check current state, advance one clock, update model
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic mr);
        logic mis;
        logic acc;
        logic pop;
        ent_t e;
        req_valid = v; req_addr = a; req_wdata = d; req_size = sz; mem_ready = mr;
        check_outputs();
        ref_align(a, d, sz, mis, e);
        acc = v && (q.size() < DEPTH);
        pop = (q.size() != 0) && mr;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc && !mis) q.push_back(e);
        exp_mis = acc && mis;
    endtask

    task automatic async_reset();
        req_valid = 1'b0; mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_misalign",  32'(misalign),  32'd0);
        q.delete();
        exp_mis = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; mem_ready = 1'b0; exp_mis = 1'b0;
        #12 reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();

        // 1: sb to lane 3
        step(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'd0, 1'b1);
        chk("t1_addr",  mem_addr,        32'h0000_1000);
        chk("t1_wdata", mem_wdata,       32'hA5A5_A5A5);
        chk("t1_be",    32'(mem_be),     32'h8);
        chk("t1_mis",   32'(misalign),   32'd0);

        // 2: sh upper half, then misaligned sh
        step(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'd1, 1'b1);
        chk("t2_wdata", mem_wdata,       32'hBEEF_BEEF);
        chk("t2_be",    32'(mem_be),     32'hC);
        step(1'b1, 32'h0000_2001, 32'h1234_BEEF, 2'd1, 1'b1);
        chk("t2_mis",   32'(misalign),   32'd1);
        chk("t2_count", 32'(count),      32'd0);
        chk("t2_mval",  32'(mem_valid),  32'd0);
        step(1'b0, '0, '0, 2'd0, 1'b1);

        // 3: fill while stalled, then drain in order
        step(1'b1, 32'h0000_4000, 32'h1111_1111, 2'd2, 1'b0);
        step(1'b1, 32'h0000_4004, 32'h2222_2222, 2'd2, 1'b0);
        chk("t3_count", 32'(count),      32'd2);
        chk("t3_ready", 32'(req_ready),  32'd0);
        step(1'b1, 32'h0000_4008, 32'h3333_3333, 2'd2, 1'b0);
        chk("t3_head",  mem_addr,        32'h0000_4000);
        step(1'b0, '0, '0, 2'd0, 1'b1);
        chk("t3_cnt1",  32'(count),      32'd1);
        chk("t3_head2", mem_wdata,       32'h2222_2222);
        step(1'b0, '0, '0, 2'd0, 1'b1);
        chk("t3_cnt0",  32'(count),      32'd0);

        // 4: simultaneous push and pop at count 1
        step(1'b1, 32'h0000_5000, 32'hAAAA_0000, 2'd2, 1'b0);
        step(1'b1, 32'h0000_5004, 32'hBBBB_0000, 2'd2, 1'b1);
        chk("t4_count", 32'(count),      32'd1);
        chk("t4_head",  mem_addr,        32'h0000_5004);

        // 5: async reset while full and stalled
        step(1'b1, 32'h0000_6000, 32'hCCCC_0000, 2'd2, 1'b0);
        step(1'b0, '0, '0, 2'd0, 1'b0);
        async_reset();
        check_outputs();

        // 6: illegal size
        step(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 2'd3, 1'b1);
        chk("t6_mis",   32'(misalign),   32'd1);
        chk("t6_ready", 32'(req_ready),  32'd1);
        chk("t6_count", 32'(count),      32'd0);

        // Random traffic with occasional asynchronous reset
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step(1'($urandom_range(0, 3) != 0), a, $urandom(), sz,
                 1'($urandom_range(0, 2) != 0));
            if (i % 150 == 149) async_reset();
        end
        step(1'b0, '0, '0, 2'd0, 1'b1);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
